board_initializer: RTL and testbench

Parametrised board-memory initializer for the Othello core. On a start request it walks every cell of a bordered (N+2)x(N+2) board RAM, writing wall, empty or starting-disc codes according to a selectable opening mode. An optional read-back pass checks each cell against the expected code. It sits between the top-level game controller and the board RAM write/read port and runs before every new game.

---
 rtl/othello_pkg.sv | 11 +
 rtl/board_cell_encoder.sv | 24 ++
 rtl/board_initializer.sv | 133 +++++++++++++
 tb/tb_board_initializer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/othello_pkg.sv
// othello_pkg: shared cell codes, opening modes and initializer states
package othello_pkg;
  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] BLACK = 2'b01;
  localparam logic [1:0] WHITE = 2'b10;
  localparam logic [1:0] WALL  = 2'b11;
  localparam logic [1:0] MODE_STD   = 2'b00;
  localparam logic [1:0] MODE_SWAP  = 2'b01;
  localparam logic [1:0] MODE_CLEAR = 2'b10;
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_VERIFY, S_DONE} state_t;
endpackage

// File: rtl/board_cell_encoder.sv
// board_cell_encoder: maps a bordered-board (row, col) and opening mode to its cell code
module board_cell_encoder #(
  parameter int N = 8,
  parameter int RC_W = $clog2(N + 2)
) (
  input  logic [RC_W-1:0] r,
  input  logic [RC_W-1:0] c,
  input  logic [1:0]      mode,
  output logic [1:0]      code
);
  import othello_pkg::*;
  localparam logic [RC_W-1:0] EDGE = RC_W'(N + 1);
  localparam logic [RC_W-1:0] LO = RC_W'(N / 2);
  localparam logic [RC_W-1:0] HI = RC_W'(N / 2 + 1);
  logic wall, diag, anti, swap;
  assign wall = r == '0 || r == EDGE || c == '0 || c == EDGE;
  assign diag = (r == LO && c == LO) || (r == HI && c == HI);
  assign anti = (r == LO && c == HI) || (r == HI && c == LO);
  assign swap = mode == MODE_SWAP;
  assign code = wall ? WALL :
                mode == MODE_CLEAR ? EMPTY :
                diag ? (swap ? WHITE : BLACK) :
                anti ? (swap ? BLACK : WHITE) : EMPTY;
endmodule

// File: rtl/board_initializer.sv
// board_initializer: writes the opening position into the board RAM and optionally reads it back to verify
module board_initializer #(
  parameter int N = 8,
  parameter int VERIFY = 1,
  parameter int RD_LAT = 1,
  localparam int SIDE = N + 2,
  localparam int CELLS = SIDE * SIDE,
  localparam int ADDR_W = $clog2(CELLS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic              ready,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] err_addr,
  output logic [ADDR_W-1:0] addr,
  output logic [1:0]        data,
  output logic              wren,
  output logic              rden,
  input  logic [1:0]        rdata
);
  import othello_pkg::*;
  localparam int RC_W = $clog2(SIDE);
  localparam int PW = 3 + ADDR_W;
  localparam logic [RC_W-1:0] EDGE = RC_W'(SIDE - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);
  state_t state, state_nx;
  logic [RC_W-1:0] r, c, r_nx, c_nx, r_inc, c_inc;
  logic [ADDR_W-1:0] addr_nx, err_addr_nx, cmp_addr;
  logic [1:0] mode_q, mode_nx, code, cmp_code;
  logic wren_nx, rden_nx, done_nx, error_nx, last, cmp_v;
  logic [RD_LAT:0][PW-1:0] pipe;
  // one encoder serves both the write data and the expected-value pipeline
  board_cell_encoder #(.N(N), .RC_W(RC_W)) u_enc (
    .r(r_nx), .c(c_nx), .mode(mode_nx), .code(code)
  );
  assign last = r == EDGE && c == EDGE;
  assign c_inc = c == EDGE ? '0 : c + 1'b1;
  assign r_inc = c == EDGE ? r + 1'b1 : r;
  assign {cmp_v, cmp_code, cmp_addr} = pipe[RD_LAT];
  // next-state and next-output decode; every output is registered from these
  always_comb begin
    state_nx = state;
    r_nx = r;
    c_nx = c;
    addr_nx = addr;
    mode_nx = mode_q;
    wren_nx = 1'b0;
    rden_nx = 1'b0;
    done_nx = 1'b0;
    error_nx = error;
    err_addr_nx = err_addr;
    case (state)
      S_IDLE: if (start) begin
        state_nx = S_WRITE;
        mode_nx = mode;
        error_nx = 1'b0;
        err_addr_nx = '0;
        r_nx = '0;
        c_nx = '0;
        addr_nx = '0;
        wren_nx = 1'b1;
      end
      S_WRITE: if (!last) begin
        r_nx = r_inc;
        c_nx = c_inc;
        addr_nx = addr + 1'b1;
        wren_nx = 1'b1;
      end else if (VERIFY != 0) begin
        state_nx = S_VERIFY;
        r_nx = '0;
        c_nx = '0;
        addr_nx = '0;
        rden_nx = 1'b1;
      end else begin
        state_nx = S_DONE;
        done_nx = 1'b1;
      end
      S_VERIFY: begin
        if (rden && !last) begin
          r_nx = r_inc;
          c_nx = c_inc;
          addr_nx = addr + 1'b1;
          rden_nx = 1'b1;
        end
        if (cmp_v && cmp_code != rdata && !error) begin
          error_nx = 1'b1;
          err_addr_nx = cmp_addr;
        end
        if (cmp_v && cmp_addr == LAST_ADDR) begin
          state_nx = S_DONE;
          done_nx = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= S_IDLE;
    else state <= state_nx;
  // registered outputs, counters and the expected-code delay line matching RAM read latency
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      r <= '0;
      c <= '0;
      addr <= '0;
      data <= EMPTY;
      mode_q <= MODE_STD;
      wren <= 1'b0;
      rden <= 1'b0;
      done <= 1'b0;
      ready <= 1'b1;
      error <= 1'b0;
      err_addr <= '0;
      pipe <= '0;
    end else begin
      r <= r_nx;
      c <= c_nx;
      addr <= addr_nx;
      data <= wren_nx ? code : EMPTY;
      mode_q <= mode_nx;
      wren <= wren_nx;
      rden <= rden_nx;
      done <= done_nx;
      ready <= state_nx == S_IDLE;
      error <= error_nx;
      err_addr <= err_addr_nx;
      pipe <= {pipe[RD_LAT-1:0], {rden_nx, code, addr_nx}};
    end
endmodule

// File: tb/tb_board_initializer.sv
// tb_board_initializer: checks three initializer configurations against a board-rule model
module tb_board_initializer;
  logic clock = 1'b0, reset = 1'b0, start = 1'b0;
  logic [1:0] mode = 2'b00;
  int sel = 0, stuck = -1, checks = 0, failures = 0;
  always #5 clock = ~clock;

  logic start_a, ready_a, done_a, error_a, wren_a, rden_a;
  logic [6:0] err_addr_a, addr_a;
  logic [1:0] data_a, rdata_a;
  logic start_b, ready_b, done_b, error_b, wren_b, rden_b;
  logic [6:0] err_addr_b, addr_b;
  logic [1:0] data_b, rdata_b, rd_b1;
  logic start_c, ready_c, done_c, error_c, wren_c, rden_c;
  logic [5:0] err_addr_c, addr_c;
  logic [1:0] data_c, rdata_c;
  logic [1:0] ram_b [0:127];
  logic [1:0] ram_c [0:63];
  logic [1:0] cap [0:127];

  assign start_a = start && sel == 0;
  assign start_b = start && sel == 1;
  assign start_c = start && sel == 2;
  assign rdata_a = 2'b00;

  board_initializer #(.N(8), .VERIFY(0), .RD_LAT(1)) dut_a (
    .clock(clock), .reset(reset), .start(start_a), .mode(mode), .ready(ready_a), .done(done_a),
    .error(error_a), .err_addr(err_addr_a), .addr(addr_a), .data(data_a), .wren(wren_a),
    .rden(rden_a), .rdata(rdata_a));
  board_initializer #(.N(8), .VERIFY(1), .RD_LAT(2)) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .mode(mode), .ready(ready_b), .done(done_b),
    .error(error_b), .err_addr(err_addr_b), .addr(addr_b), .data(data_b), .wren(wren_b),
    .rden(rden_b), .rdata(rdata_b));
  board_initializer #(.N(6), .VERIFY(1), .RD_LAT(1)) dut_c (
    .clock(clock), .reset(reset), .start(start_c), .mode(mode), .ready(ready_c), .done(done_c),
    .error(error_c), .err_addr(err_addr_c), .addr(addr_c), .data(data_c), .wren(wren_c),
    .rden(rden_c), .rdata(rdata_c));

  // RAM models; the cell at index 'stuck' always reads back as 00
  always @(posedge clock) begin
    if (wren_b) ram_b[addr_b] <= data_b;
    rd_b1 <= (rden_b && int'(addr_b) != stuck) ? ram_b[addr_b] : 2'b00;
    rdata_b <= rd_b1;
    if (wren_c) ram_c[addr_c] <= data_c;
    rdata_c <= (rden_c && int'(addr_c) != stuck) ? ram_c[addr_c] : 2'b00;
  end

  logic v_ready, v_done, v_error, v_wren, v_rden;
  logic [6:0] v_addr, v_err_addr;
  logic [1:0] v_data;
  assign v_ready = sel == 0 ? ready_a : sel == 1 ? ready_b : ready_c;
  assign v_done = sel == 0 ? done_a : sel == 1 ? done_b : done_c;
  assign v_error = sel == 0 ? error_a : sel == 1 ? error_b : error_c;
  assign v_wren = sel == 0 ? wren_a : sel == 1 ? wren_b : wren_c;
  assign v_rden = sel == 0 ? rden_a : sel == 1 ? rden_b : rden_c;
  assign v_addr = sel == 0 ? addr_a : sel == 1 ? addr_b : {1'b0, addr_c};
  assign v_err_addr = sel == 0 ? err_addr_a : sel == 1 ? err_addr_b : {1'b0, err_addr_c};
  assign v_data = sel == 0 ? data_a : sel == 1 ? data_b : data_c;

  typedef struct {int sel; logic [1:0] m; int a; logic [1:0] code;} vec_t;
  vec_t tbl[$];

  function automatic logic [1:0] model(input int n, input int a, input logic [1:0] m);
    int side = n + 2;
    int r = a / side;
    int c = a % side;
    int h = n / 2;
    logic sw = m == 2'b01;
    if (r == 0 || r == side - 1 || c == 0 || c == side - 1) return 2'b11;
    if (m == 2'b10) return 2'b00;
    if ((r == h && c == h) || (r == h + 1 && c == h + 1)) return sw ? 2'b10 : 2'b01;
    if ((r == h && c == h + 1) || (r == h + 1 && c == h)) return sw ? 2'b01 : 2'b10;
    return 2'b00;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic run(input int s, input logic [1:0] m, input int pulse_at);
    int n, cells, lat, done_exp, writes, reads, dones, done_cyc, order_bad, overlap, ea_exp;
    bit ver, err_exp;
    logic err_seen;
    logic [6:0] ea_seen;
    string tag;
    sel = s;
    n = s == 2 ? 6 : 8;
    cells = (n + 2) * (n + 2);
    ver = s != 0;
    lat = s == 1 ? 2 : 1;
    done_exp = ver ? 2 * cells + lat : cells;
    err_exp = ver && stuck >= 0 && model(n, stuck, m) != 2'b00;
    ea_exp = err_exp ? stuck : 0;
    tag = $sformatf("dut%0d mode%0d", s, m);
    writes = 0; reads = 0; dones = 0; done_cyc = -1; order_bad = 0; overlap = 0;
    err_seen = 1'b0; ea_seen = '0;
    for (int i = 0; i < 128; i++) cap[i] = 2'b00;
    @(negedge clock);
    start = 1'b1;
    mode = m;
    tick();
    start = 1'b0;
    mode = 2'($urandom);
    check({tag, " err_clear"}, {v_error, v_err_addr}, 0);
    for (int k = 0; k < done_exp + 3; k++) begin
      if (v_wren) begin
        if (int'(v_addr) != writes) order_bad++;
        cap[v_addr] = v_data;
        writes++;
      end
      if (v_rden) begin
        if (int'(v_addr) != reads) order_bad++;
        reads++;
      end
      if (v_wren && v_rden) overlap++;
      if (v_done) begin
        dones++;
        if (done_cyc < 0) begin
          done_cyc = k;
          err_seen = v_error;
          ea_seen = v_err_addr;
        end
      end
      start = k == pulse_at;
      tick();
    end
    start = 1'b0;
    check({tag, " writes"}, writes, cells);
    check({tag, " reads"}, reads, ver ? cells : 0);
    check({tag, " order"}, order_bad, 0);
    check({tag, " wren_rden_overlap"}, overlap, 0);
    check({tag, " done_count"}, dones, 1);
    check({tag, " done_cycle"}, done_cyc, done_exp);
    check({tag, " error"}, err_seen, err_exp);
    check({tag, " err_addr"}, ea_seen, ea_exp);
    check({tag, " ready_after"}, v_ready, 1);
    for (int a = 0; a < cells; a++)
      check($sformatf("%s cell%0d", tag, a), cap[a], model(n, a, m));
    foreach (tbl[i])
      if (tbl[i].sel == s && tbl[i].m == m)
        check($sformatf("%s table addr%0d", tag, tbl[i].a), cap[tbl[i].a], tbl[i].code);
  endtask

  initial begin
    int extra, s, m, cells;
    bit found;
    #12;
    for (int i = 0; i < 3; i++) begin
      sel = i;
      #1;
      check($sformatf("reset_values dut%0d", i),
            {v_ready, v_done, v_error, v_wren, v_rden, v_addr, v_err_addr, v_data}, 1 << 20);
    end
    @(negedge clock);
    reset = 1'b1;
    tbl.push_back('{0, 2'b00, 0, 2'b11});  tbl.push_back('{0, 2'b00, 11, 2'b00});
    tbl.push_back('{0, 2'b00, 19, 2'b11}); tbl.push_back('{0, 2'b00, 44, 2'b01});
    tbl.push_back('{0, 2'b00, 45, 2'b10}); tbl.push_back('{0, 2'b00, 54, 2'b10});
    tbl.push_back('{0, 2'b00, 55, 2'b01}); tbl.push_back('{0, 2'b00, 99, 2'b11});
    tbl.push_back('{0, 2'b01, 44, 2'b10}); tbl.push_back('{0, 2'b01, 45, 2'b01});
    tbl.push_back('{0, 2'b01, 0, 2'b11});  tbl.push_back('{0, 2'b10, 44, 2'b00});
    tbl.push_back('{0, 2'b10, 45, 2'b00}); tbl.push_back('{0, 2'b10, 54, 2'b00});
    tbl.push_back('{0, 2'b10, 55, 2'b00}); tbl.push_back('{0, 2'b10, 99, 2'b11});
    tbl.push_back('{0, 2'b11, 44, 2'b01}); tbl.push_back('{2, 2'b00, 27, 2'b01});
    tbl.push_back('{2, 2'b00, 28, 2'b10}); tbl.push_back('{2, 2'b00, 35, 2'b10});
    tbl.push_back('{2, 2'b00, 36, 2'b01}); tbl.push_back('{2, 2'b00, 63, 2'b11});
    run(0, 2'b00, -1);
    run(0, 2'b01, -1);
    run(0, 2'b10, -1);
    run(0, 2'b11, -1);
    run(2, 2'b00, -1);
    run(0, 2'b00, 30);
    stuck = 55;
    run(1, 2'b00, -1);
    stuck = -1;
    run(1, 2'b00, -1);
    run(2, 2'b01, 40);
    // reset in the middle of the write pass
    sel = 0;
    @(negedge clock);
    start = 1'b1;
    mode = 2'b00;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++)
      if (v_wren && v_addr == 7'd30) found = 1'b1;
      else tick();
    check("reach_addr30", found, 1);
    #2 reset = 1'b0;
    #1;
    check("reset_mid wren", wren_a, 0);
    check("reset_mid ready", ready_a, 1);
    check("reset_mid addr", addr_a, 0);
    extra = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (wren_a) extra++;
    end
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (wren_a) extra++;
    end
    check("reset_mid no_writes", extra, 0);
    run(0, 2'b00, -1);
    // start held high re-triggers right after the idle cycle that follows done
    @(negedge clock);
    start = 1'b1;
    mode = 2'b01;
    found = 1'b0;
    for (int k = 0; k < 120 && !found; k++) begin
      tick();
      if (v_done) found = 1'b1;
    end
    check("b2b first_done", found, 1);
    tick();
    check("b2b idle_cycle", {v_ready, v_wren}, 2);
    tick();
    check("b2b restart", {v_wren, v_addr}, 128);
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 120 && !found; k++) begin
      tick();
      if (v_done) found = 1'b1;
    end
    check("b2b second_done", found, 1);
    tick();
    repeat (6) begin
      s = $urandom_range(0, 2);
      m = $urandom_range(0, 3);
      cells = s == 2 ? 64 : 100;
      stuck = (s != 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(0, cells - 1)) : -1;
      run(s, 2'(m), $urandom_range(0, 1) == 1 ? int'($urandom_range(1, 50)) : -1);
      stuck = -1;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
